// File: rtl/mem_stage_lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - funct3 size field encodings and the sign/zero select bit
//   - FSM state encoding
//   - default ResultSrcM encoding that marks a load
//   - helpers that build byte enables and lane-replicated store data
// ----------------------------------------------------------------------------
package lsu_pkg;

    // funct3[1:0] access size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // funct3[2] set means zero-extend (lbu/lhu)
    localparam int F3_UNSIGNED_BIT = 2;

    // ResultSrcM value identifying a load
    localparam logic [1:0] LOAD_SRC_DEF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_R = 2'b01,
        ST_DONE   = 2'b10
    } lsu_state_t;

    // Byte enables from access size and byte offset. A halfword only looks at
    // offset[1], so a misaligned half still lands on a legal half lane; size
    // 2'b11 falls through to word.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned store data across every lane it could hit,
    // so the byte enables alone pick the destination.
    function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_if
// Data-bus interface between the load/store unit (master) and memory (slave).
//   bus_req    master->slave  request valid
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned address
//   bus_be     master->slave  byte enables
//   bus_wdata  master->slave  lane-replicated store data
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  raw read word
// ----------------------------------------------------------------------------
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load data alignment and extension.
//   i_rdata   raw 32-bit read word
//   i_addr    byte offset of the load (captured at issue)
//   i_funct3  load funct3 (size in [1:0], unsigned in [2])
//   o_data    right-aligned, sign- or zero-extended result
// ----------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_sext = ~i_funct3[F3_UNSIGNED_BIT];

        case (i_funct3[1:0])
            SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit. Turns the M-stage instruction into a data-bus
// request with a gnt/rvalid handshake, builds byte enables and replicated
// store data, extends load data and stalls the pipeline while an access is
// outstanding.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   MemWriteM      store in M
//   ResultSrcM     load in M when equal to LOAD_SRC
//   ALUResultM     effective byte address
//   WriteDataM     right-aligned store data
//   funct3M        access size/sign
//   bus            mem_stage_lsu_if master modport (data bus)
//   ReadDataM      registered, extended load result
//   StallM         freeze F/D/E/M
//   MisalignM      misaligned access flag
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses are
//                         not issued and raise MisalignM instead. When
//                         undefined, MisalignM is 0 and the offending low
//                         address bits are ignored for lane selection.
// ----------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] LOAD_SRC = LOAD_SRC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        funct3M,
    mem_stage_lsu_if.master   bus,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM
);

    lsu_state_t  r_state;
    logic [31:0] r_read_data;
    logic [1:0]  r_ld_off;
    logic [2:0]  r_ld_f3;

    logic        w_is_store;
    logic        w_is_load;
    logic        w_access;
    logic        w_misalign;
    logic        w_issue;
    logic [31:0] w_ext;

    // Store wins if both flags are set.
    assign w_is_store = MemWriteM;
    assign w_is_load  = ~MemWriteM & (ResultSrcM == LOAD_SRC);
    assign w_access   = w_is_store | w_is_load;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (funct3M[1:0])
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = ALUResultM[0];
            default: w_misalign = |ALUResultM[1:0];
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // A request goes out only from IDLE; WAIT_R and DONE ignore the held
    // instruction so it is never issued twice.
    assign w_issue = (r_state == ST_IDLE) & w_access & ~w_misalign;

    assign bus.bus_req   = w_issue;
    assign bus.bus_we    = MemWriteM;
    assign bus.bus_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
    assign bus.bus_be    = be_gen(funct3M[1:0], ALUResultM[1:0]);
    assign bus.bus_wdata = wdata_gen(funct3M[1:0], WriteDataM);

    assign MisalignM = (r_state == ST_IDLE) & w_access & w_misalign;
    assign ReadDataM = r_read_data;

    always_comb begin
        case (r_state)
            // Store granted this cycle costs no stall; a load always stalls.
            ST_IDLE:   StallM = w_issue & (w_is_load | ~bus.bus_gnt);
            ST_WAIT_R: StallM = 1'b1;
            default:   StallM = 1'b0;
        endcase
    end

    load_extend u_load_extend (
        .i_rdata  (bus.bus_rdata),
        .i_addr   (r_ld_off),
        .i_funct3 (r_ld_f3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_read_data <= '0;
            r_ld_off    <= '0;
            r_ld_f3     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Capture lane info at issue so extension does not depend
                    // on inputs once the load is in flight.
                    if (w_issue && w_is_load && bus.bus_gnt) begin
                        r_ld_off <= ALUResultM[1:0];
                        r_ld_f3  <= funct3M;
                        r_state  <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (bus.bus_rvalid) begin
                        r_read_data <= w_ext;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed testbench for mem_stage_lsu. Inputs change 1 ns after the rising
// edge; outputs are sampled 5 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu_if #(.ADDR_W(32)) bus_if ();

    mem_stage_lsu #(.ADDR_W(32), .LOAD_SRC(2'b01)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .bus        (bus_if.master),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (posedge + 5 ns).
    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        MemWriteM         = 1'b0;
        ResultSrcM        = 2'b00;
        ALUResultM        = 32'h0;
        WriteDataM        = 32'h0;
        funct3M           = 3'b000;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;
    endtask

    // Load with grant in the first cycle and rvalid three cycles after grant.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp);
        MemWriteM      = 1'b0;
        ResultSrcM     = 2'b01;
        ALUResultM     = addr;
        funct3M        = f3;
        bus_if.bus_gnt = 1'b1;
        settle();
        chk({tag, ".req"},   {31'b0, bus_if.bus_req}, 32'h1);
        chk({tag, ".we"},    {31'b0, bus_if.bus_we}, 32'h0);
        chk({tag, ".stall0"}, {31'b0, StallM}, 32'h1);
        tick();
        bus_if.bus_gnt   = 1'b0;
        bus_if.bus_rdata = 32'h5A5A5A5A;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk({tag, ".wait_stall"}, {31'b0, StallM}, 32'h1);
            chk({tag, ".wait_req"},   {31'b0, bus_if.bus_req}, 32'h0);
            tick();
        end
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = rdata;
        settle();
        chk({tag, ".rv_stall"}, {31'b0, StallM}, 32'h1);
        tick();
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;
        settle();
        chk({tag, ".done_stall"}, {31'b0, StallM}, 32'h0);
        chk({tag, ".done_req"},   {31'b0, bus_if.bus_req}, 32'h0);
        chk({tag, ".data"},       ReadDataM, exp);
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        chk("rst.rdata",    ReadDataM, 32'h0);
        chk("rst.req",      {31'b0, bus_if.bus_req}, 32'h0);
        chk("rst.stall",    {31'b0, StallM}, 32'h0);
        chk("rst.misalign", {31'b0, MisalignM}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // sw 0x100, granted same cycle: no stall
        MemWriteM      = 1'b1;
        ALUResultM     = 32'h100;
        WriteDataM     = 32'hDEADBEEF;
        funct3M        = 3'b010;
        bus_if.bus_gnt = 1'b1;
        settle();
        chk("sw.req",   {31'b0, bus_if.bus_req}, 32'h1);
        chk("sw.we",    {31'b0, bus_if.bus_we}, 32'h1);
        chk("sw.addr",  bus_if.bus_addr, 32'h100);
        chk("sw.be",    {28'b0, bus_if.bus_be}, 32'hF);
        chk("sw.wdata", bus_if.bus_wdata, 32'hDEADBEEF);
        chk("sw.stall", {31'b0, StallM}, 32'h0);
        tick();
        idle_inputs();
        settle();
        chk("sw.after_stall", {31'b0, StallM}, 32'h0);
        chk("sw.after_req",   {31'b0, bus_if.bus_req}, 32'h0);
        tick();

        // sb 0x103, grant delayed two cycles: exactly two stall cycles
        MemWriteM  = 1'b1;
        ALUResultM = 32'h103;
        WriteDataM = 32'h000000AB;
        funct3M    = 3'b000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sb.stall", {31'b0, StallM}, 32'h1);
            chk("sb.req",   {31'b0, bus_if.bus_req}, 32'h1);
            chk("sb.addr",  bus_if.bus_addr, 32'h100);
            chk("sb.be",    {28'b0, bus_if.bus_be}, 32'h8);
            chk("sb.wdata", bus_if.bus_wdata, 32'hABABABAB);
            tick();
        end
        bus_if.bus_gnt = 1'b1;
        settle();
        chk("sb.gnt_stall", {31'b0, StallM}, 32'h0);
        chk("sb.gnt_be",    {28'b0, bus_if.bus_be}, 32'h8);
        tick();
        idle_inputs();
        tick();

        // sh 0x102 lane selection
        MemWriteM  = 1'b1;
        ALUResultM = 32'h102;
        WriteDataM = 32'h00001234;
        funct3M    = 3'b001;
        bus_if.bus_gnt = 1'b1;
        settle();
        chk("sh.be",    {28'b0, bus_if.bus_be}, 32'hC);
        chk("sh.wdata", bus_if.bus_wdata, 32'h12341234);
        tick();
        idle_inputs();
        tick();

        // Loads
        do_load("lb",  32'h102, 3'b000, 32'h00800000, 32'hFFFFFF80);
        do_load("lbu", 32'h102, 3'b100, 32'h00800000, 32'h00000080);
        do_load("lh",  32'h102, 3'b001, 32'h80010000, 32'hFFFF8001);
        do_load("lhu", 32'h102, 3'b101, 32'h80010000, 32'h00008001);
        do_load("lw",  32'h200, 3'b010, 32'h8765F00D, 32'h8765F00D);
        do_load("lb0", 32'h100, 3'b000, 32'h0000007F, 32'h0000007F);

        // Reset while in WAIT_R, then a stray rvalid
        MemWriteM      = 1'b0;
        ResultSrcM     = 2'b01;
        ALUResultM     = 32'h104;
        funct3M        = 3'b010;
        bus_if.bus_gnt = 1'b1;
        tick();
        idle_inputs();
        settle();
        chk("rstw.pre_stall", {31'b0, StallM}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rstw.rdata", ReadDataM, 32'h0);
        chk("rstw.stall", {31'b0, StallM}, 32'h0);
        tick();
        reset_n = 1'b1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hFFFFFFFF;
        tick();
        bus_if.bus_rvalid = 1'b0;
        settle();
        chk("rstw.stray_rdata", ReadDataM, 32'h0);
        chk("rstw.stray_stall", {31'b0, StallM}, 32'h0);
        tick();
        // Still IDLE: a fresh store granted at once must not stall.
        MemWriteM      = 1'b1;
        ALUResultM     = 32'h108;
        funct3M        = 3'b010;
        bus_if.bus_gnt = 1'b1;
        settle();
        chk("rstw.idle_req",   {31'b0, bus_if.bus_req}, 32'h1);
        chk("rstw.idle_stall", {31'b0, StallM}, 32'h0);
        tick();
        idle_inputs();
        tick();

        // Misaligned lw at 0x101, no grant offered
        ResultSrcM = 2'b01;
        ALUResultM = 32'h101;
        funct3M    = 3'b010;
        settle();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis.flag",  {31'b0, MisalignM}, 32'h1);
        chk("mis.req",   {31'b0, bus_if.bus_req}, 32'h0);
        chk("mis.stall", {31'b0, StallM}, 32'h0);
        tick();
        settle();
        chk("mis.flag2", {31'b0, MisalignM}, 32'h1);
        chk("mis.rdata", ReadDataM, 32'h0);
`else
        chk("mis.flag",  {31'b0, MisalignM}, 32'h0);
        chk("mis.req",   {31'b0, bus_if.bus_req}, 32'h1);
        chk("mis.be",    {28'b0, bus_if.bus_be}, 32'hF);
        chk("mis.addr",  bus_if.bus_addr, 32'h100);
        chk("mis.stall", {31'b0, StallM}, 32'h1);
        // Misaligned half at 0x103 uses addr[1] only
        MemWriteM = 1'b1;
        ALUResultM = 32'h103;
        funct3M   = 3'b001;
        settle();
        chk("mish.be",   {28'b0, bus_if.bus_be}, 32'hC);
`endif
        tick();
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit that consumes the Execute→Memory pipeline register outputs: MemWriteM, ResultSrcM, ALUResultM, WriteDataM and funct3M.
- Converts each M-stage memory instruction into a request on a data bus with a gnt/rvalid handshake.
- Generates byte enables and store-data lane replication, and sign/zero-extends load data.
- Asserts StallM to freeze the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of ALUResultM and bus_addr.
- LOAD_SRC, 2'b01, ResultSrcM encoding that identifies a load.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MemWriteM  input  1  store instruction in M.
- ResultSrcM  input  2  a load is present when this equals LOAD_SRC.
- ALUResultM  input  ADDR_W  effective byte address.
- WriteDataM  input  32  store data, right-aligned.
- funct3M  input  3  access size and sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- bus_req  output  1  request valid.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_W  word-aligned address, {ALUResultM[ADDR_W-1:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_gnt  input  1  request accepted this cycle.
- bus_rvalid  input  1  read data valid.
- bus_rdata  input  32  raw read word.
- ReadDataM  output  32  extended load result, registered.
- StallM  output  1  freeze F/D/E/M registers.
- MisalignM  output  1  misaligned access flag (see Optional Feature).

Behaviour:
- States: IDLE, WAIT_R, DONE.
- access = MemWriteM | (ResultSrcM==LOAD_SRC). A store takes precedence if both are set.
- Async reset, any state → IDLE. Reset values: ReadDataM=0, state=IDLE. Combinational outputs after reset: bus_req=0, StallM=0, MisalignM=0.
- IDLE:
  - bus_req = access (combinational). bus_we = MemWriteM.
  - Store: StallM = !bus_gnt, so a store granted in the same cycle costs zero stall. Without gnt, remain in IDLE and keep stalling.
  - Load: StallM=1. On bus_gnt go to WAIT_R.
- WAIT_R:
  - bus_req=0, StallM=1.
  - On bus_rvalid, capture extend(bus_rdata) into ReadDataM and go to DONE.
- DONE:
  - StallM=0, bus_req=0, and inputs are ignored, so the same held instruction is not re-issued.
  - Go to IDLE on the next cycle.
- Load timing: minimum 3 cycles in M, stalled for 2 (gnt, rvalid, DONE).
- bus_rvalid is ignored outside WAIT_R. rvalid arrives no earlier than the cycle after gnt.
- Request stability: bus_addr, bus_be, bus_wdata and bus_we are driven from M-stage inputs, which StallM holds stable until gnt.
- Byte enables, by funct3[1:0]:
  - 00: be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - 01: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{WriteDataM[15:0]}}.
  - 10: be = 4'b1111, wdata = WriteDataM.
  - 11: treated as word.
- Load extension:
  - Select the byte or half lane with addr[1:0]. The address used is captured at issue.
  - funct3[2]=1 zero-extends; otherwise sign-extends.
  - Word loads pass through unchanged.
- A reset during WAIT_R abandons the access. A late rvalid after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned access sets bus_req=0 and StallM=0, and MisalignM=1 for every cycle the access is in M.
  - ReadDataM is unchanged.
- Undefined:
  - MisalignM is tied 0.
  - Misaligned accesses are issued with the offending low address bits ignored for lane selection: halfword uses addr[1], word uses all lanes.

Decomposition:
- Package lsu_pkg: funct3 size/sign localparams, the state encoding, and LOAD_SRC default.
- Sub-module load_extend (combinational): inputs rdata, addr[1:0], funct3; output 32-bit extended data.

Test Plan:
- sw, addr 0x100, data 0xDEADBEEF, bus_gnt same cycle → bus_be=1111, bus_wdata=0xDEADBEEF, StallM=0 throughout.
- sb, addr 0x103, data 0x000000AB, gnt delayed 2 cycles → bus_be=1000, bus_wdata=0xABABABAB, StallM high for exactly 2 cycles, request fields stable.
- lb, addr 0x102, rdata 0x00800000, rvalid 3 cycles after gnt → ReadDataM=0xFFFFFF80; lbu same case → 0x00000080. StallM drops in the DONE cycle.
- lh, addr 0x102, rdata 0x8001_0000 → ReadDataM=0xFFFF8001; lhu → 0x00008001.
- Assert reset_n low while in WAIT_R, then deliver a stray rvalid → ReadDataM=0, StallM=0, no state change.
- With LSU_MISALIGN_TRAP_EN: lw at 0x101 → MisalignM=1, bus_req=0, StallM=0. Without the macro → bus_req=1, bus_be=1111.
